// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC and issues one request at a time to instruction memory.
// Returned words go into a small FIFO. The head entry {pc+4, instruction}
// is presented to IF/ID. Because the FIFO decouples the two sides, fetch
// keeps running while the pipeline is frozen. A taken branch flushes the
// FIFO and redirects the fetch PC.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   branchTaken/Address      redirect request and its word-aligned target
//   freeze                   consumer stall; the head entry is held
//   imem_req/addr            request strobe and fetch address
//   imem_rdata/valid         returned word, 1 or more cycles after the request
//   pc/instruction           head entry (request address + 4, word); 0 when empty
//   inst_valid               FIFO non-empty
//   count                    FIFO occupancy
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branchTaken,
    input  logic [31:0]              branchAddress,
    input  logic                     freeze,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_valid,
    output logic [31:0]              pc,
    output logic [31:0]              instruction,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    entry_t          fifo [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic [31:0]     fetch_pc, req_pc;
    logic            outstanding, drop;
    logic            rsp_fire, push, pop;

    // A response with no request in flight (e.g. one that was issued
    // before a reset) is simply ignored.
    assign rsp_fire = imem_valid && outstanding;
    // A taken branch kills both the incoming word and any pop in this cycle.
    assign push     = rsp_fire && !drop && !branchTaken;
    assign pop      = inst_valid && !freeze && !branchTaken;

    // Checking for space at issue time is enough. While the request is in
    // flight the occupancy can only go down, so the returned word always fits.
    assign imem_req    = !rst && !outstanding && (cnt < FULL) && !branchTaken;
    assign imem_addr   = fetch_pc;
    assign inst_valid  = (cnt != '0);
    assign count       = cnt;
    assign pc          = inst_valid ? fifo[rd_ptr].pc4  : 32'h0;
    assign instruction = inst_valid ? fifo[rd_ptr].inst : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
        end else if (branchTaken) begin
            fetch_pc <= branchAddress;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            if (rsp_fire) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else if (outstanding) begin
                // The word for the old path is still in flight. Mark it so
                // it is discarded when it returns.
                drop <= 1'b1;
            end
        end else begin
            // Issue and response are mutually exclusive (issue needs !outstanding).
            if (imem_req) begin
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
                outstanding <= 1'b1;
            end
            if (rsp_fire) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; the head outputs are gated by inst_valid.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{pc4: req_pc + 32'd4, inst: imem_rdata};
    end

    always @(posedge clk) begin
        if (!rst && push)
            assert (cnt < FULL) else $error("if_fetch_queue: push into full FIFO");
    end
endmodule
